seq_mul_sched: RTL and testbench

Two-requester round-robin scheduler sharing one W-bit sequential shift-add multiplier core. The core has a single-cycle start pulse, a single-cycle done pulse and a product output. The scheduler accepts operand pairs over valid/ready request channels, sequences the core, and returns products over valid/ready response channels. A watchdog flags a core that never asserts done. It sits between the operand sources and the multiplier core in the TT user-project top.

---
 rtl/seq_mul_pkg.sv | 16 +
 rtl/seq_mul_sched_rr_arb2.sv | 28 ++
 rtl/seq_mul_sched.sv | 162 ++++++++++++++++
 tb/tb_seq_mul_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types and defaults for the round-robin multiplier scheduler
package seq_mul_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/seq_mul_sched_rr_arb2.sv
// rtl/seq_mul_sched_rr_arb2.sv - combinational 2-way round-robin grant
// rr_ptr names the preferred requester; the other one wins only when the preferred one is idle.
module rr_arb2
  import seq_mul_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic gnt_valid,
  output logic gnt_id
);

  req_id_t pref;
  logic    pref_valid;
  logic    alt_valid;

  always_comb begin
    pref       = rr_ptr;
    pref_valid = (pref == 1'b0) ? valid0 : valid1;
    alt_valid  = (pref == 1'b0) ? valid1 : valid0;
    gnt_valid  = pref_valid | alt_valid;
    gnt_id     = pref;
    if (!pref_valid && alt_valid) begin
      gnt_id = ~pref;
    end
  end

endmodule

// File: rtl/seq_mul_sched.sv
// rtl/seq_mul_sched.sv - two-requester scheduler sharing one sequential multiplier core
// One operation in flight; a watchdog turns a silent core into an error response.
module seq_mul_sched
  import seq_mul_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_product,
  output logic               rsp0_err,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_product,
  output logic               rsp1_err,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  state_t             state_nxt;
  req_id_t            rr_ptr;
  req_id_t            owner;
  logic [WIDTH-1:0]   hold_a;
  logic [WIDTH-1:0]   hold_b;
  logic [2*WIDTH-1:0] res_product;
  logic               res_err;
  logic [WD_W-1:0]    wd_cnt;

  logic gnt_valid;
  logic gnt_id;
  logic accept;
  logic wd_last;
  logic rsp_fire;
  logic owner_ready;

  rr_arb2 u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign wd_last     = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign owner_ready = (owner == 1'b0) ? rsp0_ready : rsp1_ready;

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    rsp_fire     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_product = '0;
    rsp1_product = '0;
    rsp0_err     = 1'b0;
    rsp1_err     = 1'b0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        // Ready is only raised toward a requester whose valid is already high,
        // so a grant is always a handshake.
        if (gnt_valid) begin
          accept     = 1'b1;
          req0_ready = (gnt_id == 1'b0);
          req1_ready = (gnt_id == 1'b1);
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        mul_a     = hold_a;
        mul_b     = hold_b;
        state_nxt = WAIT;
      end
      WAIT: begin
        mul_a = hold_a;
        mul_b = hold_b;
        if (mul_done || wd_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner == 1'b0) begin
          rsp0_valid   = 1'b1;
          rsp0_product = res_product;
          rsp0_err     = res_err;
        end else begin
          rsp1_valid   = 1'b1;
          rsp1_product = res_product;
          rsp1_err     = res_err;
        end
        if (owner_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      hold_a      <= '0;
      hold_b      <= '0;
      res_product <= '0;
      res_err     <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner  <= gnt_id;
        hold_a <= (gnt_id == 1'b0) ? req0_a : req1_a;
        hold_b <= (gnt_id == 1'b0) ? req0_b : req1_b;
      end
      if (state == ISSUE) begin
        wd_cnt <= '0;
      end
      if (state == WAIT) begin
        // A done on the final watchdog cycle still counts as success.
        if (mul_done) begin
          res_product <= mul_product;
          res_err     <= 1'b0;
        end else if (wd_last) begin
          res_product <= '0;
          res_err     <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
      if (rsp_fire) begin
        rr_ptr <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_sched.sv
// tb/tb_seq_mul_sched.sv - directed self-checking bench for seq_mul_sched
module tb_seq_mul_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_product, rsp1_product;
  logic       mul_start, busy;
  logic [3:0] mul_a, mul_b;
  logic       mul_done = 1'b0;
  logic [7:0] mul_product = 8'hAA;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int s0;
  int n;
  int g;

  bit         core_alive = 1'b1;
  int         core_delay = 4;
  int         cnt = 0;
  logic [3:0] pa = '0, pb = '0;

  always #5 clk = ~clk;

  seq_mul_sched #(.WIDTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product), .rsp1_err(rsp1_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
  );

  // Core model: done pulses core_delay cycles after the start cycle; product is garbage otherwise.
  always @(negedge clk) begin
    mul_done    = 1'b0;
    mul_product = 8'hAA;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mul_done    = 1'b1;
        mul_product = {4'b0, pa} * {4'b0, pb};
      end
    end
    if (mul_start) begin
      starts++;
      if (core_alive) begin
        pa  = mul_a;
        pb  = mul_b;
        cnt = core_delay;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp0_product"}, rsp0_product, 0);
    chk({tag, "_rsp1_product"}, rsp1_product, 0);
    chk({tag, "_rsp0_err"}, rsp0_err, 0);
    chk({tag, "_rsp1_err"}, rsp1_err, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents one request and returns at the ISSUE cycle (negedge + 1).
  task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("grant_seen", seen, 1);
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      cyc++;
      if (rsp0_valid || rsp1_valid) begin seen = 1'b1; break; end
    end
    chk("rsp_seen", seen, 1);
  endtask

  task automatic ack(input int id);
    if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_zero("reset");

    // Single request, done 4 cycles after start
    s0 = starts;
    issue(0, 4'd3, 4'd5);
    chk("t1_mul_start", mul_start, 1);
    chk("t1_mul_a", mul_a, 3);
    chk("t1_mul_b", mul_b, 5);
    chk("t1_busy", busy, 1);
    wait_rsp(n);
    chk("t1_latency", n, 5);
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_product", rsp0_product, 15);
    chk("t1_err", rsp0_err, 0);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    ack(0);
    chk("t1_done_valid", rsp0_valid, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_starts", starts - s0, 1);

    // Simultaneous requests after reset
    do_reset();
    s0 = starts;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd4;
    #1;
    chk("t2_req0_ready", req0_ready, 1);
    chk("t2_req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("t2_mul_a0", mul_a, 3);
    chk("t2_req1_blocked", req1_ready, 0);
    wait_rsp(n);
    chk("t2_rsp0_valid", rsp0_valid, 1);
    chk("t2_rsp1_quiet", rsp1_valid, 0);
    chk("t2_product0", rsp0_product, 15);
    ack(0);
    chk("t2_req1_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("t2_mul_start1", mul_start, 1);
    chk("t2_mul_a1", mul_a, 7);
    chk("t2_mul_b1", mul_b, 4);
    wait_rsp(n);
    chk("t2_rsp1_valid", rsp1_valid, 1);
    chk("t2_rsp0_quiet", rsp0_valid, 0);
    chk("t2_product1", rsp1_product, 28);
    ack(1);
    chk("t2_starts", starts - s0, 2);

    // Round-robin with both valids held, then requester 1 alone
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) req0_valid = 1'b0;
      g = -1;
      for (int k = 0; k < 30; k++) begin
        #1;
        if (req0_ready) g = 0;
        else if (req1_ready) g = 1;
        if (g >= 0) break;
        @(negedge clk);
      end
      chk("t3_grant", g, (i < 4) ? (i % 2) : 1);
      wait_rsp(n);
      if (i == 5) req1_valid = 1'b0;
      if (g == 0) begin
        chk("t3_owner0", rsp0_valid, 1);
        chk("t3_product0", rsp0_product, 6);
      end else begin
        chk("t3_owner1", rsp1_valid, 1);
        chk("t3_product1", rsp1_product, 30);
      end
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk("t3_idle", busy, 0);

    // Backpressure with the largest product
    issue(0, 4'd15, 4'd15);
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", rsp0_valid, 1);
      chk("t4_product", rsp0_product, 225);
      chk("t4_err", rsp0_err, 0);
      chk("t4_busy", busy, 1);
      chk("t4_req1_ready", req1_ready, 0);
      @(negedge clk);
      #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("t4_released", rsp0_valid, 0);
    chk("t4_rr_next", req1_ready, 1);
    req1_valid = 1'b0;

    // Watchdog: dead core, done on the last WAIT cycle, done one cycle too late
    core_alive = 1'b0;
    issue(0, 4'd6, 4'd7);
    wait_rsp(n);
    chk("t5_to_cycles", n, 16);
    chk("t5_to_err", rsp0_err, 1);
    chk("t5_to_product", rsp0_product, 0);
    ack(0);
    core_alive = 1'b1;
    core_delay = 15;
    issue(0, 4'd9, 4'd9);
    wait_rsp(n);
    chk("t5_edge_cycles", n, 16);
    chk("t5_edge_err", rsp0_err, 0);
    chk("t5_edge_product", rsp0_product, 81);
    ack(0);
    core_delay = 16;
    issue(1, 4'd9, 4'd9);
    wait_rsp(n);
    chk("t5_late_cycles", n, 16);
    chk("t5_late_err", rsp1_err, 1);
    chk("t5_late_product", rsp1_product, 0);
    ack(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t5_late_ignored", busy, 0);
    end

    // Reset mid-WAIT with rr_ptr pointing at requester 1
    core_delay = 4;
    issue(0, 4'd1, 4'd2);
    wait_rsp(n);
    chk("t6_pre_product", rsp0_product, 2);
    ack(0);
    issue(1, 4'd7, 4'd7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("t6_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t6_no_rsp0", rsp0_valid, 0);
      chk("t6_no_rsp1", rsp1_valid, 0);
      chk("t6_idle", busy, 0);
    end
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t6_rr_req0", req0_ready, 1);
    chk("t6_rr_req1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: observed=stalled expected=finished");
    $fatal(1);
  end

endmodule
